// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and dcache accesses onto one RAM port.
// Data wins ties; a streak counter bounds how long fetches can starve.
module mem_arbiter #(
  parameter int IMAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int SW = $clog2(IMAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(IMAX);
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        state, nxt;
  logic [SW-1:0] streak, streak_n;
  logic          memerr_n;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
      memerr <= 1'b0;
    end else begin
      state  <= nxt;
      streak <= streak_n;
      memerr <= memerr_n;
    end
  end

  always_comb begin
    nxt      = state;
    streak_n = streak;
    memerr_n = memerr;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      IDLE: begin
        if (!iREN) streak_n = '0;
        if (dreq && !(iREN && streak == SMAX))
          nxt = DGRANT;
        else if (iREN)
          nxt = IGRANT;
      end
      IGRANT: begin
        // a dropped request aborts with no RAM traffic this cycle
        if (!iREN) begin
          nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ERROR) memerr_n = 1'b1;
          if (ramstate == ACCESS) begin
            iwait    = 1'b0;
            iload    = ramload;
            streak_n = '0;
            nxt      = IDLE;
          end
        end
      end
      DGRANT: begin
        if (!dreq) begin
          nxt = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == ERROR) memerr_n = 1'b1;
          if (ramstate == ACCESS) begin
            dwait = 1'b0;
            dload = ramload;
            if (iREN && streak != SMAX)
              streak_n = streak + SW'(1);
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference
// model checked every cycle, plus directed cycle-exact scenarios.
module tb_mem_arbiter;

  localparam int IMAX = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int ncmp, nfail;

  mem_arbiter #(.IMAX(IMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM: errc ERROR cycles, then lat BUSY cycles, then ACCESS
  logic [31:0] ram [0:1023];
  int cnt, lat, errc;
  logic req;
  assign req = ramREN | ramWEN;
  assign ramload = ram[ramaddr[9:0]];

  always_comb begin
    ramstate = 2'd0;
    if (req) begin
      if (cnt < errc) ramstate = 2'd3;
      else if (cnt < errc + lat) ramstate = 2'd1;
      else ramstate = 2'd2;
    end
  end

  always @(posedge CLK) begin
    if (req && ramstate != 2'd2) cnt <= cnt + 1;
    else cnt <= 0;
    if (ramWEN && ramstate == 2'd2) ram[ramaddr[9:0]] <= ramstore;
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: who owns the RAM, the data streak, sticky error
  int          m_own;
  int          m_streak;
  bit          m_err;
  logic [31:0] ref_mem [0:1023];
  bit          mon_on;

  always @(negedge CLK) begin
    logic [4:0]  ectl;
    logic [31:0] ea, es, eil, edl;
    bit          live, done, chk_dl;
    if (!nRST) begin
      m_own = 0; m_streak = 0; m_err = 0;
    end
    live = (m_own == 1 && iREN) || (m_own == 2 && (dREN || dWEN));
    done = live && ramstate == 2'd2;
    ectl = {1'b1, 1'b1, 1'b0, 1'b0, m_err};
    ea = 0; es = 0; eil = 0; edl = 0; chk_dl = 1;
    if (live && m_own == 1) begin
      ectl[2] = 1'b1;
      ea = iaddr;
      if (done) begin
        ectl[4] = 1'b0;
        eil = ref_mem[iaddr[9:0]];
      end
    end
    if (live && m_own == 2) begin
      ectl[2] = dREN;
      ectl[1] = dWEN;
      ea = daddr;
      es = dstore;
      if (done) begin
        ectl[3] = 1'b0;
        if (dWEN) chk_dl = 0;
        else edl = ref_mem[daddr[9:0]];
      end
    end
    if (mon_on) begin
      chk("ctl{iw,dw,rR,rW,err}", {iwait, dwait, ramREN, ramWEN, memerr},
          {27'd0, ectl});
      chk("ramaddr", ramaddr, ea);
      chk("ramstore", ramstore, es);
      chk("iload", iload, eil);
      if (chk_dl) chk("dload", dload, edl);
    end
    if (nRST) begin
      if (live && ramstate == 2'd3) m_err = 1;
      if (m_own == 0) begin
        if (!iREN) m_streak = 0;
        if ((dREN || dWEN) && !(iREN && m_streak == IMAX)) m_own = 2;
        else if (iREN) m_own = 1;
      end else if (!live) begin
        m_own = 0;
      end else if (done) begin
        if (m_own == 1) m_streak = 0;
        else begin
          if (iREN && m_streak < IMAX) m_streak++;
          if (dWEN) ref_mem[daddr[9:0]] = dstore;
        end
        m_own = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, " iwait"}, {31'd0, iwait}, 32'd1);
    chk({n, " dwait"}, {31'd0, dwait}, 32'd1);
    chk({n, " ramREN/WEN"}, {30'd0, ramREN, ramWEN}, 32'd0);
    chk({n, " ramaddr"}, ramaddr, 32'd0);
    chk({n, " memerr"}, {31'd0, memerr}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    ncmp = 0; nfail = 0; mon_on = 0;
    lat = 0; errc = 0; cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram[10'h40] = 32'h8C220004;  ref_mem[10'h40] = 32'h8C220004;
    ram[10'h0]  = 32'h00000013;  ref_mem[10'h0]  = 32'h00000013;
    quiet();
    nRST = 0;
    #3;
    chk_reset_vals("reset");
    mon_on = 1;
    step(); step();
    nRST = 1;
    step(); step();

    // Lone fetch with two BUSY cycles
    lat = 2;
    iREN = 1; iaddr = 32'h40;
    step(); settle();
    chk("fetch c1 ramREN", {31'd0, ramREN}, 32'd1);
    chk("fetch c1 ramaddr", ramaddr, 32'h40);
    chk("fetch c1 iwait", {31'd0, iwait}, 32'd1);
    step(); settle();
    chk("fetch c2 iwait", {31'd0, iwait}, 32'd1);
    step(); settle();
    chk("fetch c3 iwait", {31'd0, iwait}, 32'd0);
    chk("fetch c3 iload", iload, 32'h8C220004);
    step();
    iREN = 0;
    settle();
    chk("fetch c4 idle ramREN", {31'd0, ramREN}, 32'd0);
    chk("fetch c4 iwait", {31'd0, iwait}, 32'd1);
    step();

    // Simultaneous fetch and write, zero-latency RAM
    lat = 0;
    iREN = 1; iaddr = 32'h0;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    step(); settle();
    chk("simul c1 dwait", {31'd0, dwait}, 32'd0);
    chk("simul c1 iwait", {31'd0, iwait}, 32'd1);
    chk("simul c1 ramWEN", {31'd0, ramWEN}, 32'd1);
    step();
    dWEN = 0; daddr = 0; dstore = 0;
    settle();
    chk("simul ram write", ram[10'h100], 32'hDEADBEEF);
    chk("simul c2 iwait", {31'd0, iwait}, 32'd1);
    step(); settle();
    chk("simul c3 iwait", {31'd0, iwait}, 32'd0);
    chk("simul c3 iload", iload, 32'h00000013);
    step();
    iREN = 0;
    step();

    // Starvation bound: data held continuously alongside a fetch
    iREN = 1; iaddr = 32'h40;
    dREN = 1; daddr = 32'h100;
    for (int c = 1; c <= 20; c++) begin
      step(); settle();
      if (!dwait && !iwait) seq.push_back(3);
      else if (!dwait) seq.push_back(2);
      else if (!iwait) seq.push_back(1);
    end
    quiet();
    chk("starve pulses", seq.size(), 32'd10);
    for (int k = 0; k < seq.size() && k < 10; k++)
      chk($sformatf("starve pulse %0d", k), seq[k],
          (k % 5 == 4) ? 32'd1 : 32'd2);
    step(); step();

    // Abort: RAM busy, read dropped after one grant cycle
    lat = 3;
    dREN = 1; daddr = 32'h100;
    step(); settle();
    chk("abort c1 ramREN", {31'd0, ramREN}, 32'd1);
    step();
    dREN = 0;
    settle();
    chk("abort c2 ramREN", {31'd0, ramREN}, 32'd0);
    chk("abort c2 dwait", {31'd0, dwait}, 32'd1);
    step(); settle();
    chk("abort c3 idle", {30'd0, ramREN, dwait}, 32'd1);
    step();

    // RAM error during a fetch: two ERROR cycles then ACCESS
    lat = 0; errc = 2;
    iREN = 1; iaddr = 32'h40;
    step(); settle();
    chk("err c1 iwait", {31'd0, iwait}, 32'd1);
    chk("err c1 ramREN", {31'd0, ramREN}, 32'd1);
    step(); settle();
    chk("err c2 iwait", {31'd0, iwait}, 32'd1);
    chk("err c2 memerr", {31'd0, memerr}, 32'd1);
    step(); settle();
    chk("err c3 iwait", {31'd0, iwait}, 32'd0);
    chk("err c3 iload", iload, 32'h8C220004);
    step();
    iREN = 0; errc = 0;
    step(); step();
    chk("err sticky memerr", {31'd0, memerr}, 32'd1);

    // Reset in the middle of a data grant
    lat = 3;
    dREN = 1; daddr = 32'h40;
    step(); settle();
    chk("rst c1 ramREN", {31'd0, ramREN}, 32'd1);
    step();
    nRST = 0;
    settle();
    chk_reset_vals("rst async");
    dREN = 0;
    step();
    nRST = 1;
    step();
    lat = 0;
    dREN = 1; daddr = 32'h100;
    step(); settle();
    chk("post-rst dwait", {31'd0, dwait}, 32'd0);
    chk("post-rst dload", dload, 32'hDEADBEEF);
    step();
    quiet();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache request protocol. It accepts instruction fetches from the icache (iREN/iaddr, answered with iwait/iload) and data reads/writes from the dcache (dREN/dWEN/daddr/dstore, answered with dwait/dload). It arbitrates between them for the single-ported RAM and drives the RAM handshake. It sits between the cache pair and the RAM model. Data requests have priority, and a bounded-starvation counter guarantees that instruction fetches make progress.

## Interface
- IMAX, default 4: maximum number of consecutive data grants while iREN is pending; at this limit the next grant goes to the instruction fetch.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction fetch request; held high with a stable iaddr until the cycle iwait=0.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly one cycle when iload is valid; high otherwise.
- iload  out  32  fetched instruction word.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both high.
- daddr  in  32  data word address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly one cycle when a data access completes; high otherwise.
- dload  out  32  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramstate=ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky flag; set on any cycle with a grant active and ramstate=ERROR; cleared only by reset.

## Operation
- FSM states: IDLE, IGRANT, DGRANT. The state is registered; all outputs are combinational from the state and the inputs.
- IDLE:
  - No RAM enables asserted; iwait=dwait=1.
  - If (dREN|dWEN) and not (iREN and streak==IMAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- IGRANT:
  - Drive ramREN=1, ramaddr=iaddr.
  - When ramstate=ACCESS: drive iwait=0 and iload=ramload, then go to IDLE.
  - If iREN drops before ACCESS, abort: go to IDLE with no response and no RAM enables that cycle.
- DGRANT:
  - Drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate=ACCESS: drive dwait=0 and dload=ramload (dload is don't-care on writes), then go to IDLE.
  - Abort on dREN=dWEN=0, with the same behaviour as IGRANT.
- Streak counter:
  - Width $clog2(IMAX+1); reset value 0.
  - Increments on each completed DGRANT while iREN is high, saturating at IMAX.
  - Clears on each completed IGRANT, and clears when iREN is low in IDLE.
- ERROR:
  - The grant is held and the RAM request stays asserted; the RAM is retried until ACCESS.
  - Wait stays high throughout.
  - memerr is set.
- Unselected outputs are 0: ramaddr, ramstore, iload, dload when not driven.
- The non-granted requester always sees wait=1.

## Timing
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, memerr=0, state=IDLE, streak=0.
- Reset mid-grant: everything returns to reset values immediately (asynchronous). The in-flight request receives no response.
- Minimum latency, request to response:
  - Request rises in cycle 0 with the FSM in IDLE.
  - Grant state is entered at edge 1.
  - With ramstate=ACCESS already in cycle 1, wait=0 occurs in cycle 1.
  - The RAM adds one cycle per BUSY cycle.
- One mandatory IDLE bubble follows every completion, so back-to-back accesses complete at most every 2 cycles plus RAM latency.
- Simultaneous iREN and dREN in IDLE with streak<IMAX: data is granted first.
- A wait=0 pulse is exactly one cycle. The requester may drop or change its request in that same cycle; the arbiter must not sample it again until IDLE.

## Test plan
- Lone fetch:
  - Stimulus: iREN=1, iaddr=0x40, RAM holds 0x8C220004 at that address, RAM returns ACCESS after 2 BUSY cycles.
  - Required: ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 with iload=0x8C220004 in cycle 3 only; FSM in IDLE in cycle 4.
- Simultaneous requests:
  - Stimulus: iREN=1 with iaddr=0x0; dWEN=1 with daddr=0x100 and dstore=0xDEADBEEF; zero-latency RAM.
  - Required: write completes first (dwait low in cycle 1, RAM at 0x100 updated); then the fetch completes (iwait low in cycle 3).
- Starvation bound:
  - Stimulus: iREN held high; dREN re-asserted continuously with IMAX=4.
  - Required: exactly 4 dwait pulses, then one iwait pulse; the pattern repeats.
- Abort:
  - Stimulus: dREN=1; RAM BUSY for 3 cycles; dREN dropped after 1 cycle.
  - Required: ramREN falls the same cycle; no dwait pulse; FSM in IDLE next cycle.
- RAM error:
  - Stimulus: during IGRANT, ramstate=ERROR for 2 cycles, then ACCESS.
  - Required: iwait high through the error cycles; iwait=0 on the ACCESS cycle; memerr=1 and stays 1 until nRST.
- Reset mid-grant:
  - Stimulus: assert nRST=0 during DGRANT.
  - Required: all outputs take their reset values asynchronously; after release, the first request is served normally.
